// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one AWxDW data memory between two requesters.
//   Port 0 (core load/store) has fixed priority. Port 1 (loader/debug/DMA)
//   is protected from starvation by a wait counter that lets it override
//   port 0 after MAX_WAIT consecutive denied cycles. Either port can lock
//   the memory for back-to-back read-modify-write sequences.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   reqN/weN/lockN          per-port request, write enable, keep-ownership
//   addrN/wdatN             per-port address and write data
//   gntN                    access performed this cycle (combinational)
//   rdatN/rvldN             registered read data, one-cycle valid pulse
//   mem_wr_en/mem_addr/
//   mem_dat_in/mem_dat_out  memory interface (combinational read)
//   busy                    registered; high while a port owns the lock
module dm_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdat0,
    output logic          gnt0,
    output logic [DW-1:0] rdat0,
    output logic          rvld0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdat1,
    output logic          gnt1,
    output logic [DW-1:0] rdat1,
    output logic          rvld1,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t     state_reg;
    logic [3:0] wait_cnt_reg;
    logic       busy_reg;
    logic       gnt0_next;
    logic       gnt1_next;

    // Grant decision. Reset masks every grant so no memory write can slip
    // through while the arbiter is being reinitialised.
    always_comb begin
        gnt0_next = 1'b0;
        gnt1_next = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    if (req1 && (wait_cnt_reg == MAX_WAIT_C))
                        gnt1_next = 1'b1;
                    else if (req0)
                        gnt0_next = 1'b1;
                    else if (req1)
                        gnt1_next = 1'b1;
                end
                OWN0:    gnt0_next = req0;
                OWN1:    gnt1_next = req1;
                default: ;
            endcase
        end
    end

    assign gnt0 = gnt0_next;
    assign gnt1 = gnt1_next;
    assign busy = busy_reg;

    // Port 0 values are routed whenever port 1 is not granted; the address
    // and data are don't-care when nobody is granted because wr_en is low.
    assign mem_addr   = gnt1_next ? addr1 : addr0;
    assign mem_dat_in = gnt1_next ? wdat1 : wdat0;
    assign mem_wr_en  = (gnt0_next & we0) | (gnt1_next & we1);

    // Ownership FSM plus starvation counter. busy tracks the state that is
    // being entered so it is high exactly while the state is OWN0/OWN1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt0_next && lock0) begin
                        state_reg <= OWN0;
                        busy_reg  <= 1'b1;
                    end else if (gnt1_next && lock1) begin
                        state_reg <= OWN1;
                        busy_reg  <= 1'b1;
                    end
                end
                // The lock is released on lock=0 whether or not the owner
                // is requesting; a final unlocked access is still granted.
                OWN0: begin
                    if (!lock0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!lock1) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase

            // Counts denied port 1 cycles in any state, but the override
            // is only honoured from IDLE so it never breaks a lock.
            if (!req1 || gnt1_next)
                wait_cnt_reg <= '0;
            else if (wait_cnt_reg < MAX_WAIT_C)
                wait_cnt_reg <= wait_cnt_reg + 4'd1;
        end
    end

    // Per-port read capture: data comes from the combinational memory read
    // in the grant cycle and is presented in the following cycle.
    logic [1:0]    gnt_vec;
    logic [1:0]    we_vec;
    logic [1:0]    rvld_vec;
    logic [DW-1:0] rdat_vec [2];

    assign gnt_vec = {gnt1_next, gnt0_next};
    assign we_vec  = {we1, we0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic          rvld_reg;
            logic [DW-1:0] rdat_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rvld_reg <= 1'b0;
                    rdat_reg <= '0;
                end else begin
                    rvld_reg <= gnt_vec[gi] & ~we_vec[gi];
                    if (gnt_vec[gi] && !we_vec[gi])
                        rdat_reg <= mem_dat_out;
                end
            end

            assign rvld_vec[gi] = rvld_reg;
            assign rdat_vec[gi] = rdat_reg;
        end
    endgenerate

    assign rvld0 = rvld_vec[0];
    assign rvld1 = rvld_vec[1];
    assign rdat0 = rdat_vec[0];
    assign rdat1 = rdat_vec[1];

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a 256x8 memory model
// (combinational read, write on the rising edge). Inputs change 1 time
// unit after each rising edge; outputs are checked 1 unit later.
module tb_dm_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, lock0;
    logic [7:0] addr0, wdat0;
    logic       gnt0, rvld0;
    logic [7:0] rdat0;
    logic       req1, we1, lock1;
    logic [7:0] addr1, wdat1;
    logic       gnt1, rvld1;
    logic [7:0] rdat1;
    logic       mem_wr_en;
    logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
    logic       busy;

    logic       load;
    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .we0        (we0),
        .lock0      (lock0),
        .addr0      (addr0),
        .wdat0      (wdat0),
        .gnt0       (gnt0),
        .rdat0      (rdat0),
        .rvld0      (rvld0),
        .req1       (req1),
        .we1        (we1),
        .lock1      (lock1),
        .addr1      (addr1),
        .wdat1      (wdat1),
        .gnt1       (gnt1),
        .rdat1      (rdat1),
        .rvld1      (rvld1),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_dat_in (mem_dat_in),
        .mem_dat_out(mem_dat_out),
        .busy       (busy)
    );

    // Memory model: default contents addr ^ 0xA5, with 0x10 holding 0x5A.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 16) ? 8'h5A : (8'(i) ^ 8'hA5);
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_dat_in;
        end
    end
    assign mem_dat_out = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_rd;
        reset = 1'b1; load = 1'b1;
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdat0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdat1 = 0;
        repeat (2) @(posedge clk);
        #1;
        load = 1'b0;

        // Reset state, and requests ignored while reset is high.
        req0 = 1; we0 = 1; addr0 = 8'h10; wdat0 = 8'hFF;
        #1;
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_wr_en", 32'(mem_wr_en), 0);
        chk("rst_rvld0", 32'(rvld0), 0);
        chk("rst_rvld1", 32'(rvld1), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdat0", 32'(rdat0), 0);
        chk("rst_rdat1", 32'(rdat1), 0);
        cyc();
        reset = 0; req0 = 0; we0 = 0;
        cyc();

        // Simple port 0 read of 0x10.
        req0 = 1; we0 = 0; addr0 = 8'h10;
        #1;
        chk("rd_gnt0", 32'(gnt0), 1);
        chk("rd_gnt1", 32'(gnt1), 0);
        chk("rd_wr_en", 32'(mem_wr_en), 0);
        chk("rd_addr", 32'(mem_addr), 32'h10);
        cyc();
        req0 = 0;
        chk("rd_rvld0", 32'(rvld0), 1);
        chk("rd_rdat0", 32'(rdat0), 32'h5A);
        chk("rd_rvld1", 32'(rvld1), 0);
        cyc();
        chk("rd_rvld0_pulse", 32'(rvld0), 0);
        chk("rd_rdat0_hold", 32'(rdat0), 32'h5A);

        // Contention: port 0 wins 4 cycles, then starvation override.
        req0 = 1; we0 = 0;
        req1 = 1; we1 = 1; addr1 = 8'h80; wdat1 = 8'hC3;
        for (int k = 0; k < 4; k++) begin
            addr0 = 8'(k + 1);
            #1;
            chk("ct_gnt0", 32'(gnt0), 1);
            chk("ct_gnt1", 32'(gnt1), 0);
            cyc();
            exp_rd = 8'(k + 1) ^ 8'hA5;
            chk("ct_rvld0", 32'(rvld0), 1);
            chk("ct_rdat0", 32'(rdat0), 32'(exp_rd));
        end
        addr0 = 8'h05;
        #1;
        chk("ct_ovr_gnt1", 32'(gnt1), 1);
        chk("ct_ovr_gnt0", 32'(gnt0), 0);
        chk("ct_ovr_wr_en", 32'(mem_wr_en), 1);
        chk("ct_ovr_addr", 32'(mem_addr), 32'h80);
        cyc();
        chk("ct_mem80", 32'(mem[8'h80]), 32'hC3);
        chk("ct_wr_rvld1", 32'(rvld1), 0);
        chk("ct_rvld0_denied", 32'(rvld0), 0);
        // Counter restarted from 0: another 4 port 0 grants before port 1.
        addr1 = 8'h81; wdat1 = 8'hC4;
        for (int k = 4; k < 8; k++) begin
            addr0 = 8'(k + 1);
            #1;
            chk("ct2_gnt0", 32'(gnt0), 1);
            chk("ct2_gnt1", 32'(gnt1), 0);
            cyc();
            exp_rd = 8'(k + 1) ^ 8'hA5;
            chk("ct2_rdat0", 32'(rdat0), 32'(exp_rd));
        end
        #1;
        chk("ct2_ovr_gnt1", 32'(gnt1), 1);
        cyc();
        chk("ct2_mem81", 32'(mem[8'h81]), 32'hC4);
        req0 = 0; req1 = 0; we1 = 0;
        cyc();

        // Locked read-modify-write on port 0 while port 1 waits.
        req0 = 1; we0 = 1; lock0 = 1; addr0 = 8'h20; wdat0 = 8'h11;
        req1 = 1; we1 = 0; addr1 = 8'h80;
        #1;
        chk("lk_gnt0_wr", 32'(gnt0), 1);
        chk("lk_gnt1_a", 32'(gnt1), 0);
        chk("lk_wr_en", 32'(mem_wr_en), 1);
        cyc();
        req0 = 0; we0 = 0;
        #1;
        chk("lk_busy_gap", 32'(busy), 1);
        chk("lk_gnt1_gap", 32'(gnt1), 0);
        chk("lk_gnt0_gap", 32'(gnt0), 0);
        cyc();
        req0 = 1; we0 = 0; lock0 = 0;
        #1;
        chk("lk_busy_rd", 32'(busy), 1);
        chk("lk_gnt0_rd", 32'(gnt0), 1);
        chk("lk_gnt1_rd", 32'(gnt1), 0);
        cyc();
        req0 = 0;
        #1;
        chk("lk_rvld0", 32'(rvld0), 1);
        chk("lk_rdat0", 32'(rdat0), 32'h11);
        chk("lk_busy_idle", 32'(busy), 0);
        chk("lk_gnt1_idle", 32'(gnt1), 1);
        chk("lk_gnt0_idle", 32'(gnt0), 0);
        cyc();
        req1 = 0;
        chk("lk_rvld1", 32'(rvld1), 1);
        chk("lk_rdat1", 32'(rdat1), 32'hC3);
        cyc();

        // Port 1 write then port 0 read of the same address.
        req1 = 1; we1 = 1; addr1 = 8'h33; wdat1 = 8'h77;
        #1;
        chk("wr_gnt1", 32'(gnt1), 1);
        cyc();
        req1 = 0; we1 = 0;
        req0 = 1; we0 = 0; addr0 = 8'h33;
        #1;
        chk("raw_gnt0", 32'(gnt0), 1);
        cyc();
        req0 = 0;
        chk("raw_rvld0", 32'(rvld0), 1);
        chk("raw_rdat0", 32'(rdat0), 32'h77);
        cyc();

        // Port 1 lock held with no request: port 0 is fully blocked.
        req1 = 1; we1 = 0; lock1 = 1; addr1 = 8'h33;
        #1;
        chk("o1_gnt1", 32'(gnt1), 1);
        cyc();
        chk("o1_rdat1", 32'(rdat1), 32'h77);
        req1 = 0;
        req0 = 1; we0 = 1; addr0 = 8'h40; wdat0 = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("o1_gnt0", 32'(gnt0), 0);
            chk("o1_gnt1", 32'(gnt1), 0);
            chk("o1_wr_en", 32'(mem_wr_en), 0);
            chk("o1_busy", 32'(busy), 1);
            cyc();
        end
        lock1 = 0;
        #1;
        chk("o1_rel_gnt0", 32'(gnt0), 0);
        cyc();
        chk("o1_after_gnt0", 32'(gnt0), 1);
        chk("o1_after_wr_en", 32'(mem_wr_en), 1);
        chk("o1_after_busy", 32'(busy), 0);
        cyc();
        chk("o1_mem40", 32'(mem[8'h40]), 32'hEE);
        req0 = 0; we0 = 0;
        cyc();

        // Reset while port 0 owns the lock with a read result pending.
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 8'h10;
        #1;
        chk("rl_gnt0", 32'(gnt0), 1);
        cyc();
        chk("rl_busy", 32'(busy), 1);
        chk("rl_rvld0", 32'(rvld0), 1);
        reset = 1; we0 = 1; wdat0 = 8'h99; addr0 = 8'h33;
        #1;
        chk("rl_rst_gnt0", 32'(gnt0), 0);
        chk("rl_rst_wr_en", 32'(mem_wr_en), 0);
        cyc();
        reset = 0; req0 = 0; we0 = 0; lock0 = 0;
        chk("rl_busy_clr", 32'(busy), 0);
        chk("rl_rvld0_clr", 32'(rvld0), 0);
        chk("rl_rdat0_clr", 32'(rdat0), 0);
        chk("rl_rdat1_clr", 32'(rdat1), 0);
        chk("rl_mem33", 32'(mem[8'h33]), 32'h77);
        // Back in IDLE: a lone port 1 request is granted immediately.
        req1 = 1; we1 = 0; addr1 = 8'h10;
        #1;
        chk("rl_idle_gnt1", 32'(gnt1), 1);
        cyc();
        req1 = 0;
        chk("rl_idle_rdat1", 32'(rdat1), 32'h5A);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
